// File: rtl/alu_pipe_if.sv
// Execute-stage ALU bus: operand/opcode/tag issue side plus registered result side.
// Carries ovf_out only when ALU_PIPE_OVF_EN is defined.
interface alu_pipe_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned TAG_W = 4
);
    logic                 valid_in;
    logic [3:0]           funct;
    logic [W-1:0]         in0;
    logic [W-1:0]         in1;
    logic [W-1:0]         in2;
    logic                 carryin;
    logic [TAG_W-1:0]     tag_in;
    logic                 hold;

    logic                 valid_out;
    logic [W-1:0]         out;
    logic [2*W-1:0]       mul_out;
    logic                 carryout;
    logic                 err_out;
    logic [TAG_W-1:0]     tag_out;
`ifdef ALU_PIPE_OVF_EN
    logic                 ovf_out;
`endif

    modport master (
        output valid_in, funct, in0, in1, in2, carryin, tag_in, hold,
        input  valid_out, out, mul_out, carryout, err_out, tag_out
`ifdef ALU_PIPE_OVF_EN
        , input ovf_out
`endif
    );

    modport slave (
        input  valid_in, funct, in0, in1, in2, carryin, tag_in, hold,
        output valid_out, out, mul_out, carryout, err_out, tag_out
`ifdef ALU_PIPE_OVF_EN
        , output ovf_out
`endif
    );
endinterface

// File: rtl/alu_pipe.sv
// Parametrised fully pipelined integer ALU with uniform latency, tag passthrough and hold.
// Optional signed-overflow flag (ovf_out) enabled by defining ALU_PIPE_OVF_EN.
module alu_pipe #(
    parameter int unsigned W       = 16,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic     clock,
    input  logic     reset_n,
    alu_pipe_if.slave bus
);
    localparam int unsigned LAST = LATENCY - 1;
    localparam int unsigned W2   = 2 * W;

    typedef enum logic [3:0] {
        F_AND  = 4'd0, F_OR   = 4'd1, F_XOR  = 4'd2, F_ADD  = 4'd3, F_ADDC = 4'd4,
        F_SUB  = 4'd5, F_MUL  = 4'd6, F_SEQ  = 4'd7, F_SLTU = 4'd8, F_SLTS = 4'd9
    } funct_e;

    if (LATENCY < 2) begin : g_bad_latency
        $error("alu_pipe: LATENCY must be >= 2");
    end
    if (W < 2) begin : g_bad_width
        $error("alu_pipe: W must be >= 2");
    end

    logic [W:0]   sum_c;
    logic [W:0]   diff_c;
    logic [W-1:0] res_c;
    logic         carry_c;
    logic         err_c;
    logic         mul_c;
    logic [W2-1:0] prod_c;

    // Stage-1 compute for every op except the multiply
    always_comb begin
        sum_c   = {1'b0, bus.in0} + {1'b0, bus.in1}
                + (W+1)'(bus.carryin && (bus.funct == F_ADDC));
        diff_c  = {1'b0, bus.in0} + {1'b0, ~bus.in1} + (W+1)'(1);
        res_c   = '0;
        carry_c = 1'b0;
        err_c   = 1'b0;
        mul_c   = 1'b0;
        case (funct_e'(bus.funct))
            F_AND:  res_c = bus.in0 & bus.in1;
            F_OR:   res_c = bus.in0 | bus.in1;
            F_XOR:  res_c = bus.in0 ^ bus.in1;
            F_ADD,
            F_ADDC: begin
                res_c   = sum_c[W-1:0];
                carry_c = sum_c[W];
            end
            F_SUB: begin
                res_c   = diff_c[W-1:0];
                carry_c = diff_c[W];
            end
            F_MUL:  mul_c = 1'b1;
            F_SEQ:  res_c = W'(bus.in0 == bus.in1);
            F_SLTU: res_c = W'(bus.in0 < bus.in1);
            F_SLTS: res_c = W'($signed(bus.in0) < $signed(bus.in1));
            default: err_c = 1'b1;
        endcase
    end

`ifdef ALU_PIPE_OVF_EN
    logic ovf_c;
    always_comb begin
        ovf_c = 1'b0;
        case (bus.funct)
            F_ADD, F_ADDC: ovf_c = (bus.in0[W-1] == bus.in1[W-1]) && (sum_c[W-1] != bus.in0[W-1]);
            F_SUB:         ovf_c = (bus.in0[W-1] != bus.in1[W-1]) && (diff_c[W-1] != bus.in0[W-1]);
            default:       ovf_c = 1'b0;
        endcase
    end
    logic ovf_q [LATENCY];
`endif

    logic             vld_q   [LATENCY];
    logic [W-1:0]     res_q   [LATENCY];
    logic             carry_q [LATENCY];
    logic             err_q   [LATENCY];
    logic [TAG_W-1:0] tag_q   [LATENCY];
    logic [W2-1:0]    prod_q  [1:LAST];
    logic             mul_q;
    logic [W-1:0]     ma_q;
    logic [W-1:0]     mb_q;

    // Multiply is deferred to stage 2 so its operands come straight from a register
    assign prod_c = W2'(ma_q) * W2'(mb_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                vld_q[i]   <= 1'b0;
                res_q[i]   <= '0;
                carry_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
                tag_q[i]   <= '0;
`ifdef ALU_PIPE_OVF_EN
                ovf_q[i]   <= 1'b0;
`endif
            end
            for (int i = 1; i < LATENCY; i++) prod_q[i] <= '0;
            mul_q         <= 1'b0;
            ma_q          <= '0;
            mb_q          <= '0;
            bus.valid_out <= 1'b0;
            bus.out       <= '0;
            bus.mul_out   <= '0;
            bus.carryout  <= 1'b0;
            bus.err_out   <= 1'b0;
            bus.tag_out   <= '0;
`ifdef ALU_PIPE_OVF_EN
            bus.ovf_out   <= 1'b0;
`endif
        end else if (!bus.hold) begin
            vld_q[0]   <= bus.valid_in;
            res_q[0]   <= res_c;
            carry_q[0] <= carry_c;
            err_q[0]   <= err_c;
            tag_q[0]   <= bus.tag_in;
            mul_q      <= bus.valid_in && mul_c;
            ma_q       <= bus.in1;
            mb_q       <= bus.in2;
`ifdef ALU_PIPE_OVF_EN
            ovf_q[0]   <= ovf_c;
            ovf_q[1]   <= ovf_q[0];
`endif

            vld_q[1]   <= vld_q[0];
            res_q[1]   <= mul_q ? prod_c[W-1:0] : res_q[0];
            prod_q[1]  <= mul_q ? prod_c : '0;
            carry_q[1] <= carry_q[0];
            err_q[1]   <= err_q[0];
            tag_q[1]   <= tag_q[0];

            for (int i = 2; i < LATENCY; i++) begin
                vld_q[i]   <= vld_q[i-1];
                res_q[i]   <= res_q[i-1];
                prod_q[i]  <= prod_q[i-1];
                carry_q[i] <= carry_q[i-1];
                err_q[i]   <= err_q[i-1];
                tag_q[i]   <= tag_q[i-1];
`ifdef ALU_PIPE_OVF_EN
                ovf_q[i]   <= ovf_q[i-1];
`endif
            end

            // Bubbles retire as all-zero outputs
            bus.valid_out <= vld_q[LAST];
            bus.out       <= vld_q[LAST] ? res_q[LAST]  : '0;
            bus.mul_out   <= vld_q[LAST] ? prod_q[LAST] : '0;
            bus.carryout  <= vld_q[LAST] && carry_q[LAST];
            bus.err_out   <= vld_q[LAST] && err_q[LAST];
            bus.tag_out   <= vld_q[LAST] ? tag_q[LAST]  : '0;
`ifdef ALU_PIPE_OVF_EN
            bus.ovf_out   <= vld_q[LAST] && ovf_q[LAST];
`endif
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (W=16, LATENCY=3): directed vectors, hold, bubble and reset flush.
module tb_alu_pipe;
    localparam int unsigned W       = 16;
    localparam int unsigned LATENCY = 3;
    localparam int unsigned TAG_W   = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    alu_pipe_if #(.W(W), .TAG_W(TAG_W)) bus ();

    alu_pipe #(.W(W), .LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
        .clock   (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  f;
        logic [15:0] a, b, c;
        logic        cin;
        logic [15:0] eo;
        logic [31:0] em;
        logic        ec, ee, eov;
    } vec_t;

    typedef struct {
        logic [15:0] eo;
        logic [31:0] em;
        logic        ec, ee, eov;
        logic [3:0]  tag;
        int          issue;
        int          hsnap;
    } exp_t;

    vec_t vt [16];
    exp_t q [$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hold_total = 0;
    bit last_hold = 1'b0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        last_hold = reset_n && bus.hold;
        if (reset_n && bus.hold) hold_total++;
    end

    // Monitor: pops one expectation per fresh retirement; idle outputs must read zero
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.valid_out) begin
                if (!last_hold) begin
                    if (q.size() == 0) begin
                        chk("unexpected_valid", 64'(bus.tag_out), 64'hDEAD);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("tag",     64'(bus.tag_out),  64'(e.tag));
                        chk("out",     64'(bus.out),      64'(e.eo));
                        chk("mul_out", 64'(bus.mul_out),  64'(e.em));
                        chk("carry",   64'(bus.carryout), 64'(e.ec));
                        chk("err",     64'(bus.err_out),  64'(e.ee));
`ifdef ALU_PIPE_OVF_EN
                        chk("ovf",     64'(bus.ovf_out),  64'(e.eov));
`endif
                        chk("latency", 64'(cyc), 64'(e.issue + int'(LATENCY) + (hold_total - e.hsnap)));
                    end
                end
            end else begin
                chk("idle_zero", {bus.out, bus.mul_out, bus.carryout, bus.err_out}, 64'd0);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.hold     = 1'b0;
    endtask

    task automatic issue(input int idx, input logic [3:0] tag);
        exp_t e;
        @(negedge clk);
        bus.hold     = 1'b0;
        bus.valid_in = 1'b1;
        bus.funct    = vt[idx].f;
        bus.in0      = vt[idx].a;
        bus.in1      = vt[idx].b;
        bus.in2      = vt[idx].c;
        bus.carryin  = vt[idx].cin;
        bus.tag_in   = tag;
        e.eo = vt[idx].eo; e.em = vt[idx].em; e.ec = vt[idx].ec;
        e.ee = vt[idx].ee; e.eov = vt[idx].eov; e.tag = tag;
        e.issue = cyc + 1;
        e.hsnap = hold_total;
        q.push_back(e);
    endtask

    // Hold with a live-looking op on the bus; it must not be captured
    task automatic hold_cycle();
        @(negedge clk);
        bus.hold     = 1'b1;
        bus.valid_in = 1'b1;
        bus.funct    = 4'd3;
        bus.in0      = 16'h1111;
        bus.in1      = 16'h2222;
        bus.tag_in   = 4'hF;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        //          f      a        b        c        cin   eo        em            ec    ee    eov
        vt[0]  = '{4'd3, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0000, 32'h0,       1'b1, 1'b0, 1'b0};
        vt[1]  = '{4'd4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0001, 32'h0,       1'b1, 1'b0, 1'b0};
        vt[2]  = '{4'd5, 16'h0005, 16'h0007, 16'h0000, 1'b0, 16'hFFFE, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[3]  = '{4'd5, 16'h0007, 16'h0005, 16'h0000, 1'b1, 16'h0002, 32'h0,       1'b1, 1'b0, 1'b0};
        vt[4]  = '{4'd9, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h0001, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[5]  = '{4'd8, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h0000, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[6]  = '{4'd7, 16'h0003, 16'h0003, 16'h0000, 1'b0, 16'h0001, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[7]  = '{4'd7, 16'h0003, 16'h0004, 16'h0000, 1'b0, 16'h0000, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[8]  = '{4'd6, 16'h1234, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 32'hFFFE0001, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{4'd0, 16'hF0F0, 16'hFF00, 16'h0000, 1'b0, 16'hF000, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[10] = '{4'd1, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 16'hFFFF, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[11] = '{4'd2, 16'hAAAA, 16'hFFFF, 16'h0000, 1'b0, 16'h5555, 32'h0,       1'b0, 1'b0, 1'b0};
        vt[12] = '{4'd12, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 32'h0,      1'b0, 1'b1, 1'b0};
        vt[13] = '{4'd3, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h8000, 32'h0,       1'b0, 1'b0, 1'b1};
        vt[14] = '{4'd5, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h7FFF, 32'h0,       1'b1, 1'b0, 1'b1};
        vt[15] = '{4'd6, 16'h0000, 16'h0003, 16'h0005, 1'b1, 16'h000F, 32'h0000000F, 1'b0, 1'b0, 1'b0};

        bus.valid_in = 1'b0; bus.hold = 1'b0; bus.funct = '0; bus.carryin = 1'b0;
        bus.in0 = '0; bus.in1 = '0; bus.in2 = '0; bus.tag_in = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(bus.valid_out), 64'd0);
        chk("rst_out",   {bus.out, bus.mul_out, bus.carryout, bus.err_out}, 64'd0);
        chk("rst_tag",   64'(bus.tag_out), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle();

        // Back-to-back stream with a 2-cycle hold before op 4 and a bubble before op 10
        for (int i = 0; i < 16; i++) begin
            if (i == 4) begin
                hold_cycle();
                hold_cycle();
            end
            if (i == 10) idle();
            issue(i, 4'(i));
        end
        idle();
        drain();

        // Reset with two ops in flight: both must vanish
        issue(0, 4'hA);
        issue(8, 4'hB);
        idle();
        #2 reset_n = 1'b0;
        #1;
        chk("flush_valid", 64'(bus.valid_out), 64'd0);
        chk("flush_out",   {bus.out, bus.mul_out, bus.carryout, bus.err_out}, 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (int'(LATENCY) + 3) idle();

        // Pipeline still works after the flush
        issue(12, 4'h5);
        issue(1, 4'h6);
        idle();
        drain();
        repeat (3) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
